// File: rtl/apb_slave_regfile_pkg.sv
// apb_slave_regfile_pkg: FSM states and APB constants shared by the register-file completer.
package apb_slave_regfile_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;
  localparam logic [3:0] PSTRB_ALL  = 4'hF;
  localparam int         WORD_BYTES = 4;
  localparam logic       RESP_OKAY  = 1'b0;
  localparam logic       RESP_ERR   = 1'b1;
endpackage

// File: rtl/apb_byte_merge.sv
// apb_byte_merge: per-lane select between old register data and APB write data.
module apb_byte_merge
  import apb_slave_regfile_pkg::*;
(
  input  logic [31:0] old_data,
  input  logic [31:0] wdata,
  input  logic [3:0]  strb,
  output logic [31:0] merged
);
  for (genvar b = 0; b < WORD_BYTES; b++) begin : g_lane
    assign merged[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : old_data[8*b +: 8];
  end
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with an ID word, RW config registers and programmable wait states.
module apb_slave_regfile
  import apb_slave_regfile_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001,
  localparam int         IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic [31:0]              PADDR,
  input  logic [2:0]               PPROT,
  input  logic                     PSELx,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [31:0]              PWDATA,
  input  logic [3:0]               PSTRB,
  output logic                     PREADY,
  output logic [31:0]              PRDATA,
  output logic                     PSLVERR,
  output logic [32*NUM_REGS-1:0]   cfg_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);
  state_t           state;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;
  logic             wr_q;
  logic             unused;
  assign unused = ^PPROT;
  logic             setup;
  logic [IDX_W-1:0] addr_idx;
  logic             addr_err;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_err;
  logic             sel_wr;
  logic [31:0]      cur;
  logic [31:0]      rd_val;
  logic [31:0]      merged;
  logic             do_write;
  assign setup    = PSELx && !PENABLE;
  assign addr_idx = PADDR[IDX_W+1:2];
  assign addr_err = (|PADDR[1:0]) || (|PADDR[31:IDX_W+2]) || (32'(addr_idx) >= NUM_REGS)
                    || (PWRITE && addr_idx == '0);
  // In IDLE the transfer is being decoded live; afterwards the setup-time snapshot rules.
  assign sel_idx  = (state == ST_IDLE) ? addr_idx : idx_q;
  assign sel_err  = (state == ST_IDLE) ? addr_err : err_q;
  assign sel_wr   = (state == ST_IDLE) ? PWRITE   : wr_q;
  assign cur      = cfg_o[{sel_idx, 5'd0} +: 32];
  assign rd_val   = (sel_wr || sel_err) ? '0 : cur;
  assign do_write = (state == ST_READY) && PSELx && PENABLE && wr_q && !err_q;
  apb_byte_merge u_merge (
    .old_data (cur),
    .wdata    (PWDATA),
    .strb     (PSTRB),
    .merged   (merged)
  );
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= RESP_OKAY;
      case (state)
        ST_IDLE: if (setup) begin
          idx_q <= addr_idx;
          err_q <= addr_err;
          wr_q  <= PWRITE;
          if (WAIT_CYCLES == 0) begin
            state   <= ST_READY;
            PREADY  <= 1'b1;
            PRDATA  <= rd_val;
            PSLVERR <= sel_err ? RESP_ERR : RESP_OKAY;
          end else begin
            state <= ST_WAIT;
            cnt   <= 4'(WAIT_CYCLES - 1);
          end
        end
        ST_WAIT: if (!PSELx) state <= ST_IDLE;
        else if (cnt == '0) begin
          state   <= ST_READY;
          PREADY  <= 1'b1;
          PRDATA  <= rd_val;
          PSLVERR <= sel_err ? RESP_ERR : RESP_OKAY;
        end else cnt <= cnt - 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end
  assign cfg_o[31:0] = ID_VALUE;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    logic [31:0] r;
    always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) r <= '0;
      else if (do_write && idx_q == IDX_W'(i)) r <= merged;
    assign cfg_o[32*i +: 32] = r;
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) wr_pulse_o <= '0;
    else wr_pulse_o <= (do_write && |PSTRB) ? (NUM_REGS'(1) << idx_q) : '0;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed checks of three completers with 1, 0 and 3 wait states.
module tb_apb_slave_regfile;
  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] PADDR;
  logic [2:0]  PPROT;
  logic [2:0]  psel;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        pready  [3];
  logic [31:0] prdata  [3];
  logic        pslverr [3];
  logic [255:0] cfg    [3];
  logic [7:0]  pulse   [3];
  int total = 0;
  int bad = 0;
  logic [31:0] rd;
  logic        er;
  int          w;
  always #5 PCLK = ~PCLK;
  apb_slave_regfile #(.WAIT_CYCLES(0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PPROT(PPROT), .PSELx(psel[0]),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]),
    .cfg_o(cfg[0]), .wr_pulse_o(pulse[0]));
  apb_slave_regfile #(.WAIT_CYCLES(1)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PPROT(PPROT), .PSELx(psel[1]),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]),
    .cfg_o(cfg[1]), .wr_pulse_o(pulse[1]));
  apb_slave_regfile #(.WAIT_CYCLES(3)) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PPROT(PPROT), .PSELx(psel[2]),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]),
    .cfg_o(cfg[2]), .wr_pulse_o(pulse[2]));
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input int d, input logic [31:0] a, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rdat, output logic err, output int waits);
    int k;
    @(negedge PCLK);
    psel = '0;
    psel[d] = 1'b1;
    PENABLE = 1'b0;
    PADDR = a;
    PWRITE = wr;
    PWDATA = wd;
    PSTRB = st;
    @(negedge PCLK);
    PENABLE = 1'b1;
    k = 1;
    while (pready[d] !== 1'b1 && k < 20) begin
      @(negedge PCLK);
      k++;
    end
    chk("pready_timeout", {255'd0, pready[d]}, 256'd1);
    rdat = prdata[d];
    err = pslverr[d];
    waits = k - 1;
  endtask
  task automatic idle();
    @(negedge PCLK);
    psel = '0;
    PENABLE = 1'b0;
  endtask
  initial begin
    PRESETn = 1'b0;
    psel = '0;
    PENABLE = 1'b0;
    PADDR = '0;
    PPROT = 3'b010;
    PWRITE = 1'b0;
    PWDATA = '0;
    PSTRB = '0;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    // reset asserted while dut1 sits in WAIT for a write to reg1
    @(negedge PCLK);
    psel[1] = 1'b1; PADDR = 32'h4; PWRITE = 1'b1; PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF;
    @(negedge PCLK);
    PENABLE = 1'b1;
    chk("wait_pready_low", {255'd0, pready[1]}, 256'd0);
    PRESETn = 1'b0;
    #1;
    chk("rst_pready", {255'd0, pready[1]}, 256'd0);
    chk("rst_prdata", {224'd0, prdata[1]}, 256'd0);
    chk("rst_pslverr", {255'd0, pslverr[1]}, 256'd0);
    chk("rst_pulse", {248'd0, pulse[1]}, 256'd0);
    chk("rst_cfg_rw", {32'd0, cfg[1][255:32]}, 256'd0);
    chk("rst_cfg_id", {224'd0, cfg[1][31:0]}, {224'd0, 32'hA9B0_0001});
    idle();
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("no_partial_write", {224'd0, cfg[1][63:32]}, 256'd0);
    xfer(1, 32'h0, 1'b0, '0, '0, rd, er, w);
    chk("id_rdata", {224'd0, rd}, {224'd0, 32'hA9B0_0001});
    chk("id_err", {255'd0, er}, 256'd0);
    chk("id_waits", 256'(w), 256'd1);
    xfer(1, 32'h4, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er, w);
    chk("wr1_err", {255'd0, er}, 256'd0);
    chk("wr1_rdata_zero", {224'd0, rd}, 256'd0);
    idle();
    chk("wr1_pulse", {248'd0, pulse[1]}, 256'h02);
    chk("wr1_cfg", {224'd0, cfg[1][63:32]}, {224'd0, 32'hDEAD_BEEF});
    @(negedge PCLK);
    chk("wr1_pulse_gone", {248'd0, pulse[1]}, 256'd0);
    xfer(1, 32'h4, 1'b0, '0, '0, rd, er, w);
    chk("rd1_full", {224'd0, rd}, {224'd0, 32'hDEAD_BEEF});
    xfer(1, 32'h4, 1'b1, 32'h1234_5678, 4'b0101, rd, er, w);
    xfer(1, 32'h4, 1'b0, '0, '0, rd, er, w);
    chk("rd1_partial", {224'd0, rd}, {224'd0, 32'hDE34_BE78});
    chk("rd1_partial_err", {255'd0, er}, 256'd0);
    xfer(1, 32'h0, 1'b1, 32'h1111_1111, 4'hF, rd, er, w);
    chk("wr_id_err", {255'd0, er}, 256'd1);
    idle();
    chk("wr_id_no_pulse", {248'd0, pulse[1]}, 256'd0);
    chk("wr_id_cfg", {224'd0, cfg[1][31:0]}, {224'd0, 32'hA9B0_0001});
    xfer(1, 32'h4, 1'b1, 32'h5555_5555, 4'h0, rd, er, w);
    chk("strb0_err", {255'd0, er}, 256'd0);
    idle();
    chk("strb0_no_pulse", {248'd0, pulse[1]}, 256'd0);
    chk("strb0_cfg", {224'd0, cfg[1][63:32]}, {224'd0, 32'hDE34_BE78});
    xfer(1, 32'h20, 1'b0, '0, '0, rd, er, w);
    chk("rd_oob_err", {255'd0, er}, 256'd1);
    chk("rd_oob_rdata", {224'd0, rd}, 256'd0);
    xfer(1, 32'h6, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, w);
    chk("misalign_err", {255'd0, er}, 256'd1);
    idle();
    chk("misalign_no_pulse", {248'd0, pulse[1]}, 256'd0);
    chk("misalign_regs", {32'd0, cfg[1][255:32]}, {64'd0, 160'd0, 32'hDE34_BE78});
    // abort: PSELx dropped during the WAIT cycle of a write to reg3
    @(negedge PCLK);
    psel[1] = 1'b1; PENABLE = 1'b0; PADDR = 32'hC; PWRITE = 1'b1; PWDATA = 32'h7777_7777; PSTRB = 4'hF;
    @(negedge PCLK);
    PENABLE = 1'b1;
    chk("abort_wait", {255'd0, pready[1]}, 256'd0);
    psel = '0;
    PENABLE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("abort_pready", {255'd0, pready[1]}, 256'd0);
      chk("abort_pulse", {248'd0, pulse[1]}, 256'd0);
    end
    chk("abort_cfg", {224'd0, cfg[1][127:96]}, 256'd0);
    xfer(1, 32'hC, 1'b0, '0, '0, rd, er, w);
    chk("abort_readback", {224'd0, rd}, 256'd0);
    chk("abort_idle_waits", 256'(w), 256'd1);
    idle();
    @(negedge PCLK);
    psel[1] = 1'b1;
    PENABLE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("no_setup_ignored", {255'd0, pready[1]}, 256'd0);
    end
    idle();
    xfer(0, 32'h8, 1'b1, 32'hCAFE_F00D, 4'hF, rd, er, w);
    chk("w0_wr_waits", 256'(w), 256'd0);
    xfer(0, 32'h8, 1'b0, '0, '0, rd, er, w);
    chk("w0_rd_waits", 256'(w), 256'd0);
    chk("w0_rd_data", {224'd0, rd}, {224'd0, 32'hCAFE_F00D});
    xfer(2, 32'h8, 1'b1, 32'h0BAD_CAFE, 4'hF, rd, er, w);
    chk("w3_wr_waits", 256'(w), 256'd3);
    xfer(2, 32'h8, 1'b0, '0, '0, rd, er, w);
    chk("w3_rd_waits", 256'(w), 256'd3);
    chk("w3_rd_data", {224'd0, rd}, {224'd0, 32'h0BAD_CAFE});
    chk("w3_rd_err", {255'd0, er}, 256'd0);
    idle();
    @(negedge PCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
